// File: rtl/mem_to_reqrsp.sv
// Initiator bridge: SRAM-style req/gnt master port to reqrsp request/response.
// One registered request slot, a bounded outstanding counter and a registered
// response stage. Responses return in order and cannot be backpressured.
module mem_to_reqrsp #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   // memory-style side
   input  logic                    mem_req_i,
   output logic                    mem_gnt_o,
   input  logic                    mem_we_i,
   input  logic [DATA_WIDTH/8-1:0] mem_be_i,
   input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
   input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
   output logic                    mem_rvalid_o,
   output logic [DATA_WIDTH-1:0]   mem_rdata_o,
   output logic                    mem_err_o,
   // reqrsp request channel
   output logic                    q_valid_o,
   input  logic                    q_ready_i,
   output logic [ADDR_WIDTH-1:0]   q_addr_o,
   output logic                    q_write_o,
   output logic [DATA_WIDTH-1:0]   q_data_o,
   output logic [DATA_WIDTH/8-1:0] q_strb_o,
   output logic [2:0]              q_size_o,
   // reqrsp response channel
   input  logic                    p_valid_i,
   output logic                    p_ready_o,
   input  logic [DATA_WIDTH-1:0]   p_data_i,
   input  logic                    p_error_i
);

   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic             slot_free;
   logic             p_hs;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [2:0]       size_d;
   logic [DATA_WIDTH-1:0] data_d;

   // Map byte enables onto a log2 access size; irregular patterns issue full word.
   function automatic logic [2:0] be_to_size(input logic [BE_W-1:0] be);
      logic [2:0] sz;
      sz = 3'd2;
      case (be)
         BE_W'(4'b1111): sz = 3'd2;
         BE_W'(4'b0011),
         BE_W'(4'b1100): sz = 3'd1;
         BE_W'(4'b0001),
         BE_W'(4'b0010),
         BE_W'(4'b0100),
         BE_W'(4'b1000): sz = 3'd0;
         default:        sz = 3'd2;
      endcase
      return sz;
   endfunction

   // Grant when the slot can take a new entry and the outstanding budget allows it.
   always_comb begin
      slot_free = !q_valid_o || q_ready_i;
      mem_gnt_o = mem_req_i && slot_free && (cnt_q < CNT_W'(MAX_OUTSTANDING));
      p_ready_o = (cnt_q != '0);
      p_hs      = p_valid_i && p_ready_o;
      size_d    = be_to_size(mem_be_i);
      data_d    = mem_we_i ? mem_wdata_i : '0;
   end

   // Outstanding count: grant increments, response handshake decrements.
   always_comb begin
      cnt_d = cnt_q;
      if (mem_gnt_o && !p_hs) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!mem_gnt_o && p_hs) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Outstanding counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Request slot: load on grant, hold under backpressure, empty after handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_valid_o <= 1'b0;
         q_addr_o  <= '0;
         q_write_o <= 1'b0;
         q_data_o  <= '0;
         q_strb_o  <= '0;
         q_size_o  <= '0;
      end else if (mem_gnt_o) begin
         q_valid_o <= 1'b1;
         q_addr_o  <= mem_addr_i;
         q_write_o <= mem_we_i;
         q_data_o  <= data_d;
         q_strb_o  <= mem_be_i;
         q_size_o  <= size_d;
      end else if (q_ready_i) begin
         q_valid_o <= 1'b0;
      end
   end

   // Response stage: one-cycle rvalid pulse per accepted response, rdata held.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_rvalid_o <= 1'b0;
         mem_err_o    <= 1'b0;
         mem_rdata_o  <= '0;
      end else begin
         mem_rvalid_o <= p_hs;
         mem_err_o    <= p_hs && p_error_i;
         if (p_hs) begin
            mem_rdata_o <= p_data_i;
         end
      end
   end

endmodule
